// File: rtl/spi_cfg_frame_slave_pkg.sv
// spi_cfg_pkg: shared state encoding, command constants and frame-length helper for the SPI config slave.
package spi_cfg_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} spi_cfg_state_e;
  localparam logic CMD_RD = 1'b1;
  localparam int SPI_CFG_MIN_DIV = 8;
  function automatic int cmd_len(input int asize);
    return 1 + asize;
  endfunction
endpackage

// File: rtl/spi_cfg_frame_slave_if.sv
// spi_cfg_frame_slave_if: SPI pins plus the config register bus driven by the frame slave.
interface spi_cfg_frame_slave_if #(
  parameter int ASIZE = 15,
  parameter int DSIZE = 16
);
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  logic [ASIZE-1:0] reg_addr;
  logic [DSIZE-1:0] reg_wdata;
  logic reg_wr_en;
  logic reg_rd_en;
  logic [DSIZE-1:0] reg_rdata;
  logic busy;
  logic frame_err;
  modport slave (
    input spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, frame_err
  );
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    input spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, frame_err
  );
endinterface

// File: rtl/spi_cfg_frame_slave_pin_sync.sv
// spi_cfg_pin_sync: STAGES-deep synchronizer for one SPI pin with an extra flop for rise/fall detection.
module spi_cfg_pin_sync #(
  parameter int STAGES = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES:0] r_sync;
  always_ff @(posedge clock or posedge rst)
    if (rst) r_sync <= {(STAGES + 1){INIT}};
    else r_sync <= {r_sync[STAGES-1:0], i_pin};
  assign o_level = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_sync[STAGES];
  assign o_fall = ~r_sync[STAGES-1] & r_sync[STAGES];
endmodule

// File: rtl/spi_cfg_frame_slave.sv
// spi_cfg_frame_slave: oversampled SPI mode-0 slave decoding {R/W, addr, data} frames onto the config register bus.
// SPI_CFG_BURST_EN: stay in DATA after each word, auto-incrementing reg_addr until cs_n rises.
module spi_cfg_frame_slave
  import spi_cfg_pkg::*;
#(
  parameter int ASIZE = 15,
  parameter int DSIZE = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic rst,
  spi_cfg_frame_slave_if.slave bus
);
  localparam int CMD_LEN = cmd_len(ASIZE);
  localparam int CW = $clog2(1 + ASIZE + DSIZE) + 1;
  localparam int SW = (CMD_LEN > DSIZE) ? CMD_LEN : DSIZE;
  localparam logic [CW-1:0] CNT_CMD = CW'(CMD_LEN);
  localparam logic [CW-1:0] CNT_END = CW'(CMD_LEN + DSIZE);
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;
  spi_cfg_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clock(clock), .rst(rst), .i_pin(bus.spi_sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_cfg_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clock(clock), .rst(rst), .i_pin(bus.spi_cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_cfg_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clock(clock), .rst(rst), .i_pin(bus.spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  assign w_unused = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};
  spi_cfg_state_e r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [SW-2:0] r_sr;
  logic [SW-1:0] w_din;
  logic [ASIZE-1:0] r_addr;
  logic [DSIZE-1:0] r_wdata, r_tx;
  logic r_rd, r_word, r_wr_en, r_rd_en, r_err, r_oe, r_fresh;
  logic w_shift, w_cmd_end, w_word_end, w_wr, w_rd, w_err;
  // a cs_n rise in the same cycle as an sclk edge discards the sclk edge
  assign w_shift = (r_state == CMD || r_state == DATA) && w_sclk_rise && !w_cs_rise;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_din = {r_sr, w_mosi};
  assign w_cmd_end = w_shift && r_state == CMD && w_cnt_nxt == CNT_CMD;
  assign w_word_end = w_shift && r_state == DATA && w_cnt_nxt == CNT_END;
  always_comb begin
    w_next = r_state;
    w_wr = 1'b0;
    w_rd = 1'b0;
    w_err = 1'b0;
    if (w_cs_rise) begin
      w_next = IDLE;
      w_err = r_state == CMD || (r_state == DATA && !r_word);
    end else if (r_state == IDLE && w_cs_fall) begin
      w_next = CMD;
    end else if (w_cmd_end) begin
      w_next = DATA;
      w_rd = w_din[ASIZE] == CMD_RD;
    end else if (w_word_end) begin
`ifdef SPI_CFG_BURST_EN
      w_rd = r_rd;
`else
      w_next = WAIT_CS;
`endif
      w_wr = !r_rd;
    end
  end
  always_ff @(posedge clock or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_sr <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_tx <= '0;
      r_rd <= 1'b0;
      r_word <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_err <= 1'b0;
      r_oe <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      r_wr_en <= w_wr;
      r_rd_en <= w_rd;
      r_err <= w_err;
      if (r_state == IDLE && w_cs_fall) begin
        r_cnt <= '0;
        r_word <= 1'b0;
      end else if (w_shift) r_cnt <= w_word_end ? CNT_CMD : w_cnt_nxt;
      if (w_shift) r_sr <= w_din[SW-2:0];
      if (w_word_end) r_word <= 1'b1;
      if (w_cmd_end) begin
        r_addr <= w_din[ASIZE-1:0];
        r_rd <= w_din[ASIZE] == CMD_RD;
      end
`ifdef SPI_CFG_BURST_EN
      else if ((w_word_end && r_rd) || r_wr_en) r_addr <= r_addr + 1'b1;
`endif
      if (w_wr) r_wdata <= w_din[DSIZE-1:0];
      // the falling edge right after a load would skip the MSB, so it is swallowed
      if (r_rd_en) begin
        r_tx <= bus.reg_rdata;
        r_oe <= 1'b1;
        r_fresh <= 1'b1;
      end else if (w_sclk_fall && r_state == DATA && !w_cs_rise) begin
        r_fresh <= 1'b0;
        if (!r_fresh) r_tx <= r_tx << 1;
      end
      if (w_cs_rise) r_oe <= 1'b0;
    end
  assign bus.reg_addr = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_wr_en = r_wr_en;
  assign bus.reg_rd_en = r_rd_en;
  assign bus.spi_miso_oe = r_oe;
  assign bus.spi_miso = r_oe && r_state == DATA && r_tx[DSIZE-1];
  assign bus.busy = r_state != IDLE;
  assign bus.frame_err = r_err;
endmodule

// File: tb/tb_spi_cfg_frame_slave.sv
// tb_spi_cfg_frame_slave: table-driven and randomized SPI frames checked against a frame-level model.
module tb_spi_cfg_frame_slave;
  import spi_cfg_pkg::*;
  localparam int A = 15;
  localparam int D = 16;
  localparam int S = 2;
  localparam int HALF = SPI_CFG_MIN_DIV / 2;
  localparam int FULL = 1 + A + D;
`ifdef SPI_CFG_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif
  typedef struct {
    logic rw;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    logic [D-1:0] rdv;
    int nbits;
    int wr;
    int rd;
    int err;
  } vec_t;
  typedef struct {
    int wr;
    int rd;
    int err;
    logic [A-1:0] waddr;
    logic [A-1:0] raddr;
    logic [D-1:0] wdata;
  } exp_t;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic [D-1:0] rd_value = '0;
  int total = 0, bad = 0, cyc = 0, last_rise_cyc = 0, proto_bad = 0;
  int n_wr = 0, n_rd = 0, n_err = 0;
  logic [A-1:0] wa_log[1024];
  logic [D-1:0] wd_log[1024];
  int wc_log[1024];
  logic [A-1:0] ra_log[1024];
  spi_cfg_frame_slave_if #(.ASIZE(A), .DSIZE(D)) sif ();
  spi_cfg_frame_slave #(.ASIZE(A), .DSIZE(D), .SYNC_STAGES(S)) dut (.clock(clock), .rst(rst), .bus(sif));
  assign sif.reg_rdata = rd_value;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (sif.reg_wr_en && n_wr < 1024) begin
      wa_log[n_wr] = sif.reg_addr;
      wd_log[n_wr] = sif.reg_wdata;
      wc_log[n_wr] = cyc;
    end
    if (sif.reg_rd_en && n_rd < 1024) ra_log[n_rd] = sif.reg_addr;
    if (sif.reg_wr_en) n_wr++;
    if (sif.reg_rd_en) n_rd++;
    if (sif.frame_err) n_err++;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  function automatic logic [63:0] outs();
    return {27'b0, sif.spi_miso, sif.spi_miso_oe, sif.reg_addr, sif.reg_wdata,
            sif.reg_wr_en, sif.reg_rd_en, sif.busy, sif.frame_err};
  endfunction
  // host side: mode 0, mosi changes while sclk is low, miso sampled just before each rise
  task automatic frame(input logic [63:0] bits, input int nbits, input bit end_cs, output logic [D-1:0] mw);
    logic is_rd;
    is_rd = bits[63];
    mw = '0;
    proto_bad = 0;
    sif.spi_cs_n = 1'b0;
    tick(2 * HALF);
    for (int i = 0; i < nbits; i++) begin
      sif.spi_sclk = 1'b0;
      sif.spi_mosi = bits[63-i];
      tick(HALF);
      if (!sif.busy) proto_bad++;
      if (!sif.spi_miso_oe && sif.spi_miso) proto_bad++;
      if (sif.spi_miso_oe !== (is_rd && i >= A + 1)) proto_bad++;
      if (i >= A + 1 && i < FULL) mw = {mw[D-2:0], sif.spi_miso};
      sif.spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(HALF);
    end
    sif.spi_sclk = 1'b0;
    if (end_cs) begin
      tick(HALF);
      sif.spi_cs_n = 1'b1;
      tick(4 * HALF);
      if (sif.busy || sif.spi_miso_oe || sif.spi_miso) proto_bad++;
    end
  endtask
  function automatic exp_t model(input logic [63:0] bits, input int nbits);
    exp_t e;
    int words;
    logic [A-1:0] addr;
    addr = bits[62:63-A];
    words = nbits < FULL ? 0 : (BURST != 0 ? (nbits - 1 - A) / D : 1);
    e.err = words == 0 ? 1 : 0;
    e.wr = bits[63] ? 0 : words;
    e.rd = (bits[63] && nbits >= A + 1) ? 1 + BURST * words : 0;
    e.raddr = addr + A'(BURST * words);
    e.waddr = addr + A'(words - 1);
    e.wdata = words > 0 ? bits[63-A-1-D*(words-1) -: D] : '0;
    return e;
  endfunction
  task automatic judge(input string tag, input int bw, input int br, input int be, input exp_t e);
    check({tag, " wr_cnt"}, 64'(n_wr - bw), 64'(e.wr));
    check({tag, " rd_cnt"}, 64'(n_rd - br), 64'(e.rd));
    check({tag, " err_cnt"}, 64'(n_err - be), 64'(e.err));
    check({tag, " protocol"}, 64'(proto_bad), 64'd0);
    if (e.wr > 0 && n_wr > bw) begin
      check({tag, " waddr"}, 64'(wa_log[n_wr-1]), 64'(e.waddr));
      check({tag, " wdata"}, 64'(wd_log[n_wr-1]), 64'(e.wdata));
    end
    if (e.rd > 0 && n_rd > br) check({tag, " raddr"}, 64'(ra_log[n_rd-1]), 64'(e.raddr));
  endtask
  initial begin
    vec_t vecs[7];
    vec_t v;
    exp_t e;
    logic [63:0] bits;
    logic [D-1:0] mw;
    int bw, br, be, nb;
    vecs[0] = '{1'b0, 15'h0012, 16'hBEEF, 16'h0000, 32, 1, 0, 0};
    vecs[1] = '{1'b1, 15'h0005, 16'h0000, 16'hA55A, 32, 0, 1 + BURST, 0};
    vecs[2] = '{1'b0, 15'h1234, 16'h5678, 16'h0000, 20, 0, 0, 1};
    vecs[3] = '{1'b0, 15'h0ABC, 16'h1357, 16'h0000, 40, 1, 0, 0};
    vecs[4] = '{1'b1, 15'h7FFF, 16'h0000, 16'h3C3C, 10, 0, 0, 1};
    vecs[5] = '{1'b1, 15'h0100, 16'h0000, 16'h0F0F, 24, 0, 1, 1};
    vecs[6] = '{1'b0, 15'h7FFF, 16'h0001, 16'h0000, 32, 1, 0, 0};
    sif.spi_cs_n = 1'b1;
    sif.spi_sclk = 1'b0;
    sif.spi_mosi = 1'b0;
    tick(3);
    check("reset outputs", outs(), 64'd0);
    rst = 1'b0;
    tick(4);
    check("idle outputs", outs(), 64'd0);
    foreach (vecs[k]) begin
      v = vecs[k];
      rd_value = v.rdv;
      bits = {v.rw, v.addr, v.data, 32'hA5C3_0F96};
      bw = n_wr;
      br = n_rd;
      be = n_err;
      frame(bits, v.nbits, 1'b1, mw);
      e = '{v.wr, v.rd, v.err, v.addr, v.addr + A'(BURST * v.rd / 2), v.data};
      judge($sformatf("vec%0d", k), bw, br, be, e);
      if (v.wr > 0 && v.nbits == FULL && n_wr > bw)
        check($sformatf("vec%0d wr latency", k), 64'(wc_log[n_wr-1] - last_rise_cyc), 64'(S + 1));
      if (v.rw && v.nbits >= FULL) check($sformatf("vec%0d miso", k), 64'(mw), 64'(v.rdv));
    end
    bw = n_wr;
    be = n_err;
    frame({1'b0, 15'h0444, 16'h9999, 32'h0}, 10, 1'b0, mw);
    rst = 1'b1;
    tick(2);
    check("mid-frame reset outputs", outs(), 64'd0);
    sif.spi_cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(8);
    check("post-reset idle", outs(), 64'd0);
    br = n_rd;
    frame({1'b0, 15'h0321, 16'hCAFE, 32'h0}, FULL, 1'b1, mw);
    judge("after reset", bw, br, be, '{1, 0, 0, 15'h0321, 15'h0, 16'hCAFE});
    bw = n_wr;
    be = n_err;
    frame({1'b0, 15'h7FFF, 16'h1111, 16'h2222, 16'h0}, FULL + D, 1'b1, mw);
    check("burst wr_cnt", 64'(n_wr - bw), 64'(1 + BURST));
    check("burst err_cnt", 64'(n_err - be), 64'd0);
    if (n_wr > bw) begin
      check("burst w0 addr", 64'(wa_log[bw]), 64'h7FFF);
      check("burst w0 data", 64'(wd_log[bw]), 64'h1111);
    end
`ifdef SPI_CFG_BURST_EN
    if (n_wr > bw + 1) begin
      check("burst w1 addr", 64'(wa_log[bw+1]), 64'h0000);
      check("burst w1 data", 64'(wd_log[bw+1]), 64'h2222);
    end
`endif
    for (int n = 0; n < 24; n++) begin
      bits = {$urandom, $urandom};
      nb = $urandom_range(0, 1) == 1 ? FULL : $urandom_range(1, BURST != 0 ? 60 : 40);
      rd_value = D'($urandom);
      e = model(bits, nb);
      bw = n_wr;
      br = n_rd;
      be = n_err;
      frame(bits, nb, 1'b1, mw);
      judge($sformatf("rand%0d", n), bw, br, be, e);
      if (bits[63] && nb >= FULL) check($sformatf("rand%0d miso", n), 64'(mw), 64'(rd_value));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
